// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between ALU and load writeback.
// Optional macro REGWB_BYPASS_EN adds a combinational forwarding path off the output stage.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] Write_data,
    output logic [CNT_W-1:0]  wr_count
`ifdef REGWB_BYPASS_EN
   ,input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              byp1_hit,
    output logic              byp2_hit,
    output logic [DATA_W-1:0] byp1_data,
    output logic [DATA_W-1:0] byp2_data
`endif
);

    typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} rr_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rr_t               rr_last;
    rr_t               rr_next;
    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Arbiter state: remembers which requester won most recently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_last <= LAST1;
        else      rr_last <= rr_next;
    end

    // Grant selection; the requester that did not win last time wins a tie.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        rr_next  = rr_last;
        sel_rd   = req0_rd;
        sel_data = req0_data;
        if (!flush) begin
            unique case (1'b1)
                (req0_valid && !req1_valid): grant0 = 1'b1;
                (req1_valid && !req0_valid): grant1 = 1'b1;
                (req0_valid && req1_valid): begin
                    grant0 = (rr_last == LAST1);
                    grant1 = (rr_last == LAST0);
                end
                default: ;
            endcase
        end
        if (grant0) begin
            rr_next = LAST0;
        end else if (grant1) begin
            rr_next  = LAST1;
            sel_rd   = req1_rd;
            sel_data = req1_data;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;

    // Output stage: one write per cycle, x0 writes are accepted but suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite   <= 1'b0;
            Rd         <= '0;
            Write_data <= '0;
        end else if (xfer) begin
            RegWrite   <= (sel_rd != '0);
            Rd         <= sel_rd;
            Write_data <= sel_data;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

    // Committed-write counter, saturating instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              wr_count <= '0;
        else if (RegWrite && wr_count != CNT_MAX) wr_count <= wr_count + 1'b1;
    end

`ifdef REGWB_BYPASS_EN
    // Forward the in-flight write so a same-cycle reader sees the new value.
    always_comb begin
        byp1_hit  = RegWrite && (Rd == rs1) && (rs1 != '0);
        byp2_hit  = RegWrite && (Rd == rs2) && (rs2 != '0);
        byp1_data = byp1_hit ? Write_data : '0;
        byp2_data = byp2_hit ? Write_data : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// A second instance with a narrow counter exercises saturation quickly.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Write_data;
    logic [15:0] wr_count;

    logic        s_req0_ready;
    logic        s_req1_ready;
    logic        s_RegWrite;
    logic [4:0]  s_Rd;
    logic [31:0] s_Write_data;
    logic [3:0]  s_wr_count;

`ifdef REGWB_BYPASS_EN
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        byp1_hit;
    logic        byp2_hit;
    logic [31:0] byp1_data;
    logic [31:0] byp2_data;
    logic        s_byp1_hit;
    logic        s_byp2_hit;
    logic [31:0] s_byp1_data;
    logic [31:0] s_byp2_data;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_rd(req0_rd),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .RegWrite(RegWrite), .Rd(Rd),
        .Write_data(Write_data), .wr_count(wr_count)
`ifdef REGWB_BYPASS_EN
       ,.rs1(rs1), .rs2(rs2),
        .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
        .byp1_data(byp1_data), .byp2_data(byp2_data)
`endif
    );

    regfile_wb_arbiter #(.CNT_W(4)) sat_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_rd(req0_rd),
        .req0_data(req0_data), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd),
        .req1_data(req1_data), .req1_ready(s_req1_ready),
        .RegWrite(s_RegWrite), .Rd(s_Rd),
        .Write_data(s_Write_data), .wr_count(s_wr_count)
`ifdef REGWB_BYPASS_EN
       ,.rs1(rs1), .rs2(rs2),
        .byp1_hit(s_byp1_hit), .byp2_hit(s_byp2_hit),
        .byp1_data(s_byp1_data), .byp2_data(s_byp2_data)
`endif
    );

    // Register-file model fed by the DUT write port.
    always @(posedge clk) begin
        if (RegWrite) rf[Rd] <= Write_data;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        req0_valid = 1'b0;
        req0_rd    = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_rd    = '0;
        req1_data  = '0;
`ifdef REGWB_BYPASS_EN
        rs1 = '0;
        rs2 = '0;
`endif
        #12;
        check("rst_regwrite", {31'b0, RegWrite}, 32'h0);
        check("rst_rd", {27'b0, Rd}, 32'h0);
        check("rst_wdata", Write_data, 32'h0);
        check("rst_count", {16'b0, wr_count}, 32'h0);
        rst = 1'b1;
        tick();

        // single ALU write to x5
        req0_valid = 1'b1;
        req0_rd    = 5'd5;
        req0_data  = 32'hA5;
        #1;
        check("t2_ready0", {31'b0, req0_ready}, 32'h1);
        check("t2_ready1", {31'b0, req1_ready}, 32'h0);
        tick();
        idle();
        check("t2_regwrite", {31'b0, RegWrite}, 32'h1);
        check("t2_rd", {27'b0, Rd}, 32'h5);
        check("t2_wdata", Write_data, 32'hA5);
        tick();
        check("t2_count", {16'b0, wr_count}, 32'h1);
        check("t2_regwrite_off", {31'b0, RegWrite}, 32'h0);

        // async reset while a write is presented
        req0_valid = 1'b1;
        req0_rd    = 5'd6;
        req0_data  = 32'h66;
        tick();
        check("t1_pre_regwrite", {31'b0, RegWrite}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("t1_regwrite", {31'b0, RegWrite}, 32'h0);
        check("t1_count", {16'b0, wr_count}, 32'h0);
        idle();
        #1;
        rst = 1'b1;
        tick();

        // both valid, alternating grants
        req0_valid = 1'b1;
        req0_rd    = 5'd3;
        req0_data  = 32'h30;
        req1_valid = 1'b1;
        req1_rd    = 5'd7;
        req1_data  = 32'h70;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t3_ready0_%0d", k), {31'b0, req0_ready},
                  (k % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("t3_ready1_%0d", k), {31'b0, req1_ready},
                  (k % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            check($sformatf("t3_regwrite_%0d", k), {31'b0, RegWrite}, 32'h1);
            check($sformatf("t3_rd_%0d", k), {27'b0, Rd},
                  (k % 2 == 0) ? 32'h3 : 32'h7);
        end
        idle();
        tick();
        check("t3_count", {16'b0, wr_count}, 32'h4);

        // same rd from both, loser written last
        req0_valid = 1'b1;
        req0_rd    = 5'd9;
        req0_data  = 32'h11;
        req1_valid = 1'b1;
        req1_rd    = 5'd9;
        req1_data  = 32'h22;
        tick();
        check("t4_rd_a", {27'b0, Rd}, 32'h9);
        check("t4_wdata_a", Write_data, 32'h11);
        req0_valid = 1'b0;
        tick();
        check("t4_rd_b", {27'b0, Rd}, 32'h9);
        check("t4_wdata_b", Write_data, 32'h22);
        idle();
        tick();
        check("t4_rf9", rf[9], 32'h22);
        check("t4_count", {16'b0, wr_count}, 32'h6);

        // x0 write is accepted but not committed
        req1_valid = 1'b1;
        req1_rd    = 5'd0;
        req1_data  = 32'hFF;
        #1;
        check("t5_ready1", {31'b0, req1_ready}, 32'h1);
        tick();
        idle();
        check("t5_regwrite", {31'b0, RegWrite}, 32'h0);
        tick();
        check("t5_count", {16'b0, wr_count}, 32'h6);

        // flush blocks grants and keeps arbiter state
        flush      = 1'b1;
        req0_valid = 1'b1;
        req0_rd    = 5'd3;
        req0_data  = 32'h33;
        req1_valid = 1'b1;
        req1_rd    = 5'd7;
        req1_data  = 32'h77;
        #1;
        check("t5_flush_ready0", {31'b0, req0_ready}, 32'h0);
        check("t5_flush_ready1", {31'b0, req1_ready}, 32'h0);
        tick();
        check("t5_flush_regwrite", {31'b0, RegWrite}, 32'h0);
        check("t5_flush_count", {16'b0, wr_count}, 32'h6);
        flush = 1'b0;
        #1;
        check("t5_post_ready0", {31'b0, req0_ready}, 32'h1);
        check("t5_post_ready1", {31'b0, req1_ready}, 32'h0);
        req1_valid = 1'b0;
        tick();
        idle();
        tick();
        check("t5_post_count", {16'b0, wr_count}, 32'h7);

`ifdef REGWB_BYPASS_EN
        // forwarding of the write presented this cycle
        req0_valid = 1'b1;
        req0_rd    = 5'd4;
        req0_data  = 32'h77;
        tick();
        idle();
        rs1 = 5'd4;
        rs2 = 5'd0;
        #1;
        check("t6_byp1_hit", {31'b0, byp1_hit}, 32'h1);
        check("t6_byp1_data", byp1_data, 32'h77);
        check("t6_byp2_hit", {31'b0, byp2_hit}, 32'h0);
        check("t6_byp2_data", byp2_data, 32'h0);
        tick();
        check("t6_byp1_idle", {31'b0, byp1_hit}, 32'h0);
`endif

        // saturation: narrow counter sticks at its maximum
        req0_valid = 1'b1;
        req0_rd    = 5'd1;
        req0_data  = 32'h1;
        for (int k = 0; k < 20; k++) tick();
        idle();
        tick();
        check("t6_sat_count", {28'b0, s_wr_count}, 32'hF);
`ifdef REGWB_BYPASS_EN
        check("t6_main_count", {16'b0, wr_count}, 32'd28);
`else
        check("t6_main_count", {16'b0, wr_count}, 32'd27);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
